// File: rtl/shift_register_pkg.sv
// ----------------------------------------------------------------------------
// shift_register_pkg
// Shared definitions for the universal shift register and its bit cell.
//   mode_e   : operation select encoding (hold / shift left / shift right /
//              parallel load)
//   is_shift : true for the two modes that advance the shift counter
// ----------------------------------------------------------------------------
package shift_register_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHL  = 2'b01,
    MODE_SHR  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  function automatic logic is_shift(input mode_e m);
    return (m == MODE_SHL) || (m == MODE_SHR);
  endfunction

endpackage

// File: rtl/shreg_cell.sv
// ----------------------------------------------------------------------------
// shreg_cell
// One bit of the shift register: a D flip-flop with asynchronous active-low
// reset, fed by a 4:1 next-value mux selected by the operation mode, with
// true and complementary outputs.
// Ports:
//   i_clk    : clock, rising edge
//   i_rst_n  : asynchronous active-low reset (clears the bit)
//   i_sel    : mode select (hold / shift left / shift right / load)
//   i_shl    : value taken on shift left (lower neighbour or fill)
//   i_shr    : value taken on shift right (upper neighbour or fill)
//   i_load   : value taken on parallel load
//   o_q      : stored bit
//   o_q_n    : complement of the stored bit
// ----------------------------------------------------------------------------
module shreg_cell
  import shift_register_pkg::*;
(
  input  logic  i_clk,
  input  logic  i_rst_n,
  input  mode_e i_sel,
  input  logic  i_shl,
  input  logic  i_shr,
  input  logic  i_load,
  output logic  o_q,
  output logic  o_q_n
);

  logic r_q;
  logic w_d;

  always_comb begin
    w_d = r_q;
    unique case (i_sel)
      MODE_HOLD: w_d = r_q;
      MODE_SHL:  w_d = i_shl;
      MODE_SHR:  w_d = i_shr;
      MODE_LOAD: w_d = i_load;
      default:   w_d = r_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= 1'b0;
    end else begin
      r_q <= w_d;
    end
  end

  assign o_q   = r_q;
  assign o_q_n = ~r_q;

endmodule

// File: rtl/shift_register.sv
// ----------------------------------------------------------------------------
// shift_register
// W-bit universal shift register (W = 2**S) built from W shreg_cell bits,
// with an S-bit shift counter that emits a one-cycle done pulse after every
// W shifts since the last load or reset.
// Configuration macro: SHREG_ROTATE_EN -- when defined, rot=1 in the shift
// modes feeds the bit falling off one end back into the other end; when
// undefined, rot is ignored and the fill always comes from sin_r / sin_l.
// Ports:
//   clk    : clock, rising edge
//   reset  : asynchronous active-low reset
//   mode   : 00 hold, 01 shift left, 10 shift right, 11 parallel load
//   rot    : rotate select for the shift modes
//   sin_l  : serial input entering bit W-1 on shift right
//   sin_r  : serial input entering bit 0 on shift left
//   din    : parallel load data
//   dout   : register contents
//   dout_n : complement of dout
//   sout_l : dout[W-1]
//   sout_r : dout[0]
//   done   : one-cycle pulse after the W-th shift since load/reset
// ----------------------------------------------------------------------------
module shift_register
  import shift_register_pkg::*;
#(
  parameter  int unsigned S = 3,
  localparam int unsigned W = 2 ** S
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [1:0]   mode,
  input  logic         rot,
  input  logic         sin_l,
  input  logic         sin_r,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [W-1:0] dout_n,
  output logic         sout_l,
  output logic         sout_r,
  output logic         done
);

  mode_e w_mode;
  assign w_mode = mode_e'(mode);

  // Rotate enable. The rot port exists in every build; without the macro it
  // is tied off here so the fill always comes from the serial inputs.
  logic w_rot;
`ifdef SHREG_ROTATE_EN
  assign w_rot = rot;
`else
  logic w_unused_rot;
  assign w_unused_rot = rot;
  assign w_rot        = 1'b0;
`endif

  logic [W-1:0] w_q;
  logic [W-1:0] w_q_n;

  // Bit entering position 0 on shift left / position W-1 on shift right.
  logic w_fill_shl;
  logic w_fill_shr;
  assign w_fill_shl = w_rot ? w_q[W-1] : sin_r;
  assign w_fill_shr = w_rot ? w_q[0]   : sin_l;

  for (genvar gi = 0; gi < int'(W); gi++) begin : g_cell
    logic w_shl_src;
    logic w_shr_src;

    if (gi == 0) begin : g_lsb
      assign w_shl_src = w_fill_shl;
    end else begin : g_shl_mid
      assign w_shl_src = w_q[gi-1];
    end

    if (gi == int'(W) - 1) begin : g_msb
      assign w_shr_src = w_fill_shr;
    end else begin : g_shr_mid
      assign w_shr_src = w_q[gi+1];
    end

    shreg_cell u_cell (
      .i_clk   (clk),
      .i_rst_n (reset),
      .i_sel   (w_mode),
      .i_shl   (w_shl_src),
      .i_shr   (w_shr_src),
      .i_load  (din[gi]),
      .o_q     (w_q[gi]),
      .o_q_n   (w_q_n[gi])
    );
  end

  // Shift counter: both directions count, load clears, hold freezes. The
  // counter naturally wraps from W-1 to 0 since it is exactly S bits wide.
  logic [S-1:0] r_cnt;
  logic [S-1:0] w_cnt_d;
  logic         r_done;
  logic         w_done_d;

  always_comb begin
    w_cnt_d  = r_cnt;
    w_done_d = 1'b0;
    if (is_shift(w_mode)) begin
      w_cnt_d  = r_cnt + 1'b1;
      w_done_d = (r_cnt == {S{1'b1}});
    end else if (w_mode == MODE_LOAD) begin
      w_cnt_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_d;
      r_done <= w_done_d;
    end
  end

  assign dout   = w_q;
  assign dout_n = w_q_n;
  assign sout_l = w_q[W-1];
  assign sout_r = w_q[0];
  assign done   = r_done;

endmodule

// File: tb/tb_shift_register.sv
module tb_shift_register;

  localparam int W    = 8;
  localparam int Span = 1 << W;

`ifdef SHREG_ROTATE_EN
  localparam bit RotEn = 1'b1;
`else
  localparam bit RotEn = 1'b0;
`endif

  logic         clk;
  logic         reset;
  logic [1:0]   mode;
  logic         rot;
  logic         sin_l;
  logic         sin_r;
  logic [W-1:0] din;
  logic [W-1:0] dout;
  logic [W-1:0] dout_n;
  logic         sout_l;
  logic         sout_r;
  logic         done;

  shift_register #(
    .S (3)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .mode   (mode),
    .rot    (rot),
    .sin_l  (sin_l),
    .sin_r  (sin_r),
    .din    (din),
    .dout   (dout),
    .dout_n (dout_n),
    .sout_l (sout_l),
    .sout_r (sout_r),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: register value as an integer, shifts counted since load.
  int m_val;
  int m_shifts;
  bit m_done;

  int n_checks;
  int n_pass;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    check({tag, "_dout"},   32'(dout),   32'(m_val));
    check({tag, "_dout_n"}, 32'(dout_n), 32'(Span - 1 - m_val));
    check({tag, "_sout_l"}, 32'(sout_l), 32'(m_val / (Span / 2)));
    check({tag, "_sout_r"}, 32'(sout_r), 32'(m_val % 2));
    check({tag, "_done"},   32'(done),   32'(m_done));
  endtask

  task automatic model_reset();
    m_val    = 0;
    m_shifts = 0;
    m_done   = 1'b0;
  endtask

  task automatic model_step(input logic [1:0] md, input logic r, input logic sl, input logic sr,
                            input logic [W-1:0] d);
    int fill;
    m_done = 1'b0;
    case (md)
      2'd1: begin
        fill     = (RotEn && r) ? m_val / (Span / 2) : int'(sr);
        m_val    = (m_val * 2) % Span + fill;
        m_shifts = m_shifts + 1;
        m_done   = (m_shifts % W) == 0;
      end
      2'd2: begin
        fill     = (RotEn && r) ? m_val % 2 : int'(sl);
        m_val    = m_val / 2 + fill * (Span / 2);
        m_shifts = m_shifts + 1;
        m_done   = (m_shifts % W) == 0;
      end
      2'd3: begin
        m_val    = int'(d);
        m_shifts = 0;
      end
      default: ;
    endcase
  endtask

  // Drive one cycle of stimulus, let the DUT clock it, then compare.
  task automatic step(input logic [1:0] md, input logic r, input logic sl, input logic sr,
                      input logic [W-1:0] d, input string tag);
    mode  = md;
    rot   = r;
    sin_l = sl;
    sin_r = sr;
    din   = d;
    @(posedge clk);
    #1;
    model_step(md, r, sl, sr, d);
    check_all(tag);
  endtask

  // Pulse reset between clock edges; outputs must clear before any edge.
  task automatic async_reset(input string tag);
    #3;
    reset = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    #2;
    reset = 1'b1;
  endtask

  logic [W-1:0] saved;

  initial begin
    n_checks = 0;
    n_pass   = 0;
    model_reset();
    reset = 1'b0;
    mode  = 2'd0;
    rot   = 1'b0;
    sin_l = 1'b0;
    sin_r = 1'b0;
    din   = '0;

    #3;
    check_all("reset_t0");
    @(posedge clk);
    #1;
    mode = 2'd3;
    din  = 8'hFF;
    @(posedge clk);
    #1;
    check_all("reset_held_load");
    reset = 1'b1;

    // Load A5.
    step(2'd3, 1'b0, 1'b0, 1'b0, 8'hA5, "load_a5");
    check("load_a5_dout_const", 32'(dout), 32'h0000_00A5);
    check("load_a5_doutn_const", 32'(dout_n), 32'h0000_005A);

    // Eight shifts left with sin_r=1 fill to FF, done on the eighth.
    for (int i = 0; i < 8; i++) step(2'd1, 1'b0, 1'b0, 1'b1, 8'h00, "shl_ones");
    check("shl_ones_ff", 32'(dout), 32'h0000_00FF);
    check("shl_ones_done", 32'(done), 32'd1);
    step(2'd0, 1'b0, 1'b0, 1'b0, 8'h00, "hold_after_done");
    check("done_one_cycle", 32'(done), 32'd0);

    // Load 81, shift right twice with rot=1, sin_l=0.
    step(2'd3, 1'b0, 1'b0, 1'b0, 8'h81, "load_81");
    step(2'd2, 1'b1, 1'b0, 1'b0, 8'h00, "shr_rot1");
`ifdef SHREG_ROTATE_EN
    check("shr_rot1_const", 32'(dout), 32'h0000_00C0);
`else
    check("shr_rot1_const", 32'(dout), 32'h0000_0040);
`endif
    step(2'd2, 1'b1, 1'b0, 1'b0, 8'h00, "shr_rot2");
`ifdef SHREG_ROTATE_EN
    check("shr_rot2_const", 32'(dout), 32'h0000_0060);
`else
    check("shr_rot2_const", 32'(dout), 32'h0000_0020);
`endif

    // Three shifts, load, then eight shifts: only the eighth post-load pulses.
    for (int i = 0; i < 3; i++) step(2'd1, 1'b0, 1'b0, 1'b1, 8'h00, "pre_load_shift");
    step(2'd3, 1'b0, 1'b0, 1'b0, 8'h5C, "reload");
    for (int i = 0; i < 7; i++) step(2'(1 + i % 2), 1'b0, 1'b1, 1'b0, 8'h00, "post_load");
    check("post_load_7_nodone", 32'(done), 32'd0);
    step(2'd1, 1'b0, 1'b0, 1'b0, 8'h00, "post_load_8");
    check("post_load_8_done", 32'(done), 32'd1);

    // Async reset mid-sequence with dout=3C, then no pulse after release.
    step(2'd3, 1'b0, 1'b0, 1'b0, 8'h1E, "load_1e");
    step(2'd1, 1'b0, 1'b0, 1'b0, 8'h00, "shl_to_3c");
    check("mid_3c", 32'(dout), 32'h0000_003C);
    async_reset("async_mid");
    check("async_zero", 32'(dout), 32'd0);
    for (int i = 0; i < 7; i++) step(2'd1, 1'b0, 1'b0, 1'b1, 8'h00, "after_rst");
    check("after_rst_nodone", 32'(done), 32'd0);
    step(2'd1, 1'b0, 1'b0, 1'b1, 8'h00, "after_rst_8");

    // Four shifts, five holds, four shifts: done after the eighth shift.
    step(2'd3, 1'b0, 1'b0, 1'b0, 8'h96, "load_96");
    for (int i = 0; i < 4; i++) step(2'd1, 1'b0, 1'b0, 1'b0, 8'h00, "pre_hold");
    saved = dout;
    for (int i = 0; i < 5; i++) begin
      step(2'd0, 1'b1, 1'b1, 1'b1, 8'hFF, "hold");
      check("hold_stable", 32'(dout), 32'(saved));
    end
    for (int i = 0; i < 4; i++) step(2'd2, 1'b0, 1'b1, 1'b0, 8'h00, "post_hold");
    check("post_hold_done", 32'(done), 32'd1);

    // Randomized traffic against the model, with occasional async resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        async_reset("rand_rst");
      end else begin
        step(2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 1'($urandom),
             8'($urandom), "rand");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/shift_register.md
SHIFT_REGISTER -- requirements
Module: shift_register

Interface
REQ-001 The block SHALL have parameter S, default 3, meaning log2 of register width; W = 2**S.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port mode, input, 2, operation select: 00 hold, 01 shift left, 10 shift right, 11 parallel load.
REQ-005 The block SHALL have port rot, input, 1, rotate select for shift modes; honoured only under SHREG_ROTATE_EN.
REQ-006 The block SHALL have port sin_l, input, 1, serial data entering bit W-1 on shift right.
REQ-007 The block SHALL have port sin_r, input, 1, serial data entering bit 0 on shift left.
REQ-008 The block SHALL have port din, input, W, parallel load data.
REQ-009 The block SHALL have port dout, output, W, register contents (true outputs).
REQ-010 The block SHALL have port dout_n, output, W, bitwise complement of dout (complementary outputs, as on the flip-flops).
REQ-011 The block SHALL have port sout_l, output, 1, equal to dout[W-1].
REQ-012 The block SHALL have port sout_r, output, 1, equal to dout[0].
REQ-013 The block SHALL have port done, output, 1, one-cycle pulse marking W completed shifts since the last load or reset.

Function
REQ-014 Hold (00) SHALL keep dout and the shift counter unchanged.
REQ-015 Shift left (01) SHALL set dout <= {dout[W-2:0], fill}, where fill = sin_r, or dout[W-1] when rotating.
REQ-016 Shift right (10) SHALL set dout <= {fill, dout[W-1:1]}, where fill = sin_l, or dout[0] when rotating.
REQ-017 Load (11) SHALL set dout <= din and clear the shift counter, with no done pulse.
REQ-018 Every mode change SHALL take effect on the next rising clk edge, with one-cycle latency from mode/data to dout.
REQ-019 The shift counter SHALL be S bits wide, increment by one on each shift cycle, and wrap from W-1 to 0.
REQ-020 done SHALL be registered: high for exactly the cycle after the shift that wraps the counter from W-1 to 0, and low otherwise.
REQ-021 Shift direction changes mid-sequence SHALL NOT reset the counter; both directions count.
REQ-022 sout_l, sout_r and dout_n SHALL be combinational from dout, with no extra latency.

Reset
REQ-023 While reset is low, dout SHALL be all zeros, dout_n all ones, sout_l and sout_r 0, the counter 0, and done 0, independent of clk.
REQ-024 Reset asserted mid-shift-sequence SHALL discard the count; the first rising clk edge after reset deasserts SHALL act on mode normally.

Configuration
REQ-025 With macro SHREG_ROTATE_EN defined, rot=1 in modes 01/10 SHALL rotate per REQ-015/016, and rot=1 in other modes SHALL be ignored.
REQ-026 With SHREG_ROTATE_EN undefined, the rot port SHALL remain present but be ignored, and fill SHALL always come from sin_r/sin_l.

Structure
REQ-027 A shared package SHALL hold mode encodings MODE_HOLD, MODE_SHL, MODE_SHR and MODE_LOAD.
REQ-028 One sub-module shreg_cell SHALL exist: a single-bit, async-active-low-reset D flip-flop with a 4:1 next-value mux and complementary outputs, instantiated W times.

Verification
REQ-029 Reset low, then load din=8'hA5 -> dout=A5, dout_n=5A, done=0 next cycle.
REQ-030 From A5, shift left with sin_r=1 for 8 cycles -> dout=FF, and done=1 in exactly the cycle after the 8th shift.
REQ-031 Under SHREG_ROTATE_EN, load 8'h81, shift right with rot=1 -> dout=C0, then 60; without the macro the same stimulus with sin_l=0 -> 40, then 20.
REQ-032 Do 3 shifts, then load, then 8 shifts -> done pulses only after the 8th post-load shift.
REQ-033 Drop reset asynchronously mid-sequence between edges with dout=3C -> dout=00 immediately, with no done pulse after release.
REQ-034 Hold for 5 cycles between the 4th and 5th shifts -> dout is stable, and done still pulses after the 8th shift.
